// File: rtl/tier2_truncation_calc_pkg.sv
// Shared widths, pass-table entry layout, FSM encoding and saturating add for the tier-2 rate controller.
// Combinational definitions only; no latency, no backpressure.
package tier2_truncation_calc_pkg;
  localparam int ADDR_W  = 10;
  localparam int BLK_W   = 6;
  localparam int LEN_W   = 12;
  localparam int SLOPE_W = 16;
  localparam int ACC_W   = 24;
  localparam int CNT_W   = 6;
  localparam int BIT_W   = $clog2(SLOPE_W);
  localparam int ENTRY_W = BLK_W + LEN_W + SLOPE_W;

  // Field order fixes the entry offsets: blk_id in the MSBs, slope in the LSBs.
  typedef struct packed {
    logic [BLK_W-1:0]   blk_id;
    logic [LEN_W-1:0]   len;
    logic [SLOPE_W-1:0] slope;
  } pass_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN0,
    ST_SEARCH,
    ST_FINAL,
    ST_DONE
  } state_t;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [LEN_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - LEN_W){1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/tier2_truncation_calc_if.sv
// Controller/pass-table/trunc-table bundle of the truncation engine; slave is the engine side.
// Plain wires; read data is expected one cycle after pass_rd_en, no backpressure.
interface tier2_truncation_calc_if;
  import tier2_truncation_calc_pkg::*;

  logic               cal_truncation_point_start;
  logic               cal_truncation_point_over;
  logic [ACC_W-1:0]   byte_budget;
  logic [ADDR_W:0]    pass_count;
  logic               pass_rd_en;
  logic [ADDR_W-1:0]  pass_addr;
  logic [ENTRY_W-1:0] pass_rd_data;
  logic               trunc_we;
  logic [BLK_W-1:0]   trunc_addr;
  logic [CNT_W-1:0]   trunc_data;
  logic [SLOPE_W:0]   threshold;
  logic [ACC_W-1:0]   total_bytes;

  modport master (
    output cal_truncation_point_start, byte_budget, pass_count, pass_rd_data,
    input  cal_truncation_point_over, pass_rd_en, pass_addr,
    input  trunc_we, trunc_addr, trunc_data, threshold, total_bytes
  );

  modport slave (
    input  cal_truncation_point_start, byte_budget, pass_count, pass_rd_data,
    output cal_truncation_point_over, pass_rd_en, pass_addr,
    output trunc_we, trunc_addr, trunc_data, threshold, total_bytes
  );
endinterface

// File: rtl/tier2_truncation_calc_pass_scanner.sv
// One pass over the table: addresses 0..count-1, 1-cycle data pipe, slope >= thresh accumulate, block-end writes.
// A scan lasts count+1 cycles (last marks the drain cycle); the final block write lands one cycle after last.
module tier2_truncation_calc_pass_scanner
  import tier2_truncation_calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_syn,
  input  logic               active,
  input  logic               wr_mode,
  input  logic [ADDR_W:0]    count,
  input  logic [SLOPE_W:0]   thresh,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  addr,
  input  logic [ENTRY_W-1:0] rd_data,
  output logic               last,
  output logic [ACC_W-1:0]   total,
  output logic               we,
  output logic [BLK_W-1:0]   we_blk,
  output logic [CNT_W-1:0]   we_cnt
);
  logic [ADDR_W:0]   idx_q;
  logic              d_vld_q;
  logic              last_q;
  logic              flush_q;
  logic [ACC_W-1:0]  acc_q;
  logic              cur_vld_q;
  logic [BLK_W-1:0]  cur_blk_q;
  logic [CNT_W-1:0]  cur_cnt_q;
  pass_entry_t       ent;
  logic              kept;
  logic              boundary;

  assign ent      = pass_entry_t'(rd_data);
  assign rd_en    = active && (idx_q < count);
  assign addr     = idx_q[ADDR_W-1:0];
  assign last     = active && (idx_q == count);
  assign kept     = d_vld_q && ({1'b0, ent.slope} >= thresh);
  // total already includes the entry in flight, so it is the scan result during the drain cycle.
  assign total    = kept ? sat_add(acc_q, ent.len) : acc_q;
  assign boundary = d_vld_q && cur_vld_q && (ent.blk_id != cur_blk_q);
  assign we       = (wr_mode && boundary) || flush_q;
  assign we_blk   = we ? cur_blk_q : '0;
  assign we_cnt   = we ? cur_cnt_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      d_vld_q   <= 1'b0;
      last_q    <= 1'b0;
      flush_q   <= 1'b0;
      acc_q     <= '0;
      cur_vld_q <= 1'b0;
      cur_blk_q <= '0;
      cur_cnt_q <= '0;
    end else if (rst_syn) begin
      idx_q     <= '0;
      d_vld_q   <= 1'b0;
      last_q    <= 1'b0;
      flush_q   <= 1'b0;
      acc_q     <= '0;
      cur_vld_q <= 1'b0;
      cur_blk_q <= '0;
      cur_cnt_q <= '0;
    end else begin
      idx_q   <= (!active || last) ? '0 : idx_q + (ADDR_W + 1)'(1);
      d_vld_q <= rd_en;
      last_q  <= last;
      flush_q <= last && wr_mode;
      acc_q   <= last ? '0 : total;
      if (last_q) begin
        cur_vld_q <= 1'b0;
      end else if (d_vld_q) begin
        cur_vld_q <= 1'b1;
        if (!cur_vld_q || (ent.blk_id != cur_blk_q)) begin
          cur_blk_q <= ent.blk_id;
          cur_cnt_q <= CNT_W'(kept);
        end else begin
          cur_cnt_q <= cur_cnt_q + CNT_W'(kept);
        end
      end
    end
  end
endmodule

// File: rtl/tier2_truncation_calc.sv
// Tier-2 rate control: bitwise search for the global slope threshold fitting byte_budget, then per-block kept counts.
// start->over = 2 + (SLOPE_W+2)*(pass_count+1) cycles (2 + 2*(pass_count+1) if everything fits); no backpressure.
module tier2_truncation_calc
  import tier2_truncation_calc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_syn,
  tier2_truncation_calc_if.slave bus
);
  state_t           state_q, state_d;
  logic [ACC_W-1:0] budget_q;
  logic [ADDR_W:0]  count_q;
  logic [SLOPE_W-1:0] tp_q;
  logic [SLOPE_W-1:0] cand;
  logic [BIT_W-1:0] bit_q;
  logic [SLOPE_W:0] t_q;
  logic [SLOPE_W:0] scan_thr;
  logic             in_done_q;
  logic             over_q;
  logic [SLOPE_W:0] thr_out_q;
  logic [ACC_W-1:0] tot_out_q;
  logic             active;
  logic             last;
  logic             over_budget;
  logic [ACC_W-1:0] scan_total;

  assign cand        = tp_q | (SLOPE_W'(1) << bit_q);
  assign over_budget = scan_total > budget_q;
  assign active      = (state_q == ST_SCAN0) || (state_q == ST_SEARCH) || (state_q == ST_FINAL);

  always_comb begin
    scan_thr = '0;
    case (state_q)
      ST_SEARCH: scan_thr = {1'b0, cand};
      ST_FINAL:  scan_thr = t_q;
      default:   scan_thr = '0;
    endcase
  end

  tier2_truncation_calc_pass_scanner u_scanner (
    .clk     (clk),
    .rst     (rst),
    .rst_syn (rst_syn),
    .active  (active),
    .wr_mode (state_q == ST_FINAL),
    .count   (count_q),
    .thresh  (scan_thr),
    .rd_en   (bus.pass_rd_en),
    .addr    (bus.pass_addr),
    .rd_data (bus.pass_rd_data),
    .last    (last),
    .total   (scan_total),
    .we      (bus.trunc_we),
    .we_blk  (bus.trunc_addr),
    .we_cnt  (bus.trunc_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else if (rst_syn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.cal_truncation_point_start)
                   state_d = (bus.pass_count == '0) ? ST_DONE : ST_SCAN0;
      ST_SCAN0:  if (last) state_d = over_budget ? ST_SEARCH : ST_FINAL;
      ST_SEARCH: if (last && (bit_q == '0)) state_d = ST_FINAL;
      ST_FINAL:  if (last) state_d = ST_DONE;
      // Wait for start to drop so a level held high cannot retrigger.
      ST_DONE:   if (!bus.cal_truncation_point_start) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      budget_q  <= '0;
      count_q   <= '0;
      tp_q      <= '0;
      bit_q     <= '0;
      t_q       <= '0;
      in_done_q <= 1'b0;
      over_q    <= 1'b0;
      thr_out_q <= '0;
      tot_out_q <= '0;
    end else if (rst_syn) begin
      budget_q  <= '0;
      count_q   <= '0;
      tp_q      <= '0;
      bit_q     <= '0;
      t_q       <= '0;
      in_done_q <= 1'b0;
      over_q    <= 1'b0;
      thr_out_q <= '0;
      tot_out_q <= '0;
    end else begin
      in_done_q <= (state_q == ST_DONE);
      over_q    <= (state_q == ST_DONE) && !in_done_q;
      case (state_q)
        ST_IDLE: if (bus.cal_truncation_point_start) begin
          budget_q <= bus.byte_budget;
          count_q  <= bus.pass_count;
          tp_q     <= '0;
          bit_q    <= BIT_W'(SLOPE_W - 1);
          if (bus.pass_count == '0) begin
            thr_out_q <= '0;
            tot_out_q <= '0;
          end
        end
        ST_SCAN0: if (last && !over_budget) t_q <= '0;
        // tp_q tracks the largest threshold known to overshoot; T is one above it.
        ST_SEARCH: if (last) begin
          if (over_budget) tp_q <= cand;
          if (bit_q == '0)
            t_q <= {1'b0, (over_budget ? cand : tp_q)} + (SLOPE_W + 1)'(1);
          else
            bit_q <= bit_q - BIT_W'(1);
        end
        ST_FINAL: if (last) begin
          thr_out_q <= t_q;
          tot_out_q <= scan_total;
        end
        default: ;
      endcase
    end
  end

  assign bus.cal_truncation_point_over = over_q;
  assign bus.threshold                 = thr_out_q;
  assign bus.total_bytes               = tot_out_q;
endmodule

// File: tb/tb_tier2_truncation_calc.sv
// Scoreboarded bench for tier2_truncation_calc: reference threshold search, trunc writes, over pulse and latency.
module tb_tier2_truncation_calc;
  import tier2_truncation_calc_pkg::*;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int thr; int tot; int lat; } res_t;

  logic clk;
  logic rst;
  logic rst_syn;
  int   cyc;
  int   start_cyc;
  int   over_cnt;
  int   n_vec;
  int   n_err;
  wr_t  wr_q[$];
  res_t res_q[$];
  wr_t  w;
  res_t r;
  pass_entry_t tbl [1024];

  tier2_truncation_calc_if bus();

  tier2_truncation_calc dut (
    .clk     (clk),
    .rst     (rst),
    .rst_syn (rst_syn),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pass-table memory: one-cycle read latency.
  always @(posedge clk)
    if (bus.pass_rd_en) bus.pass_rd_data <= tbl[bus.pass_addr];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint total_at(input int x, input int n);
    longint s = 0;
    for (int i = 0; i < n; i++)
      if (int'(tbl[i].slope) >= x) s += longint'(tbl[i].len);
    return s;
  endfunction

  // Reference: T is the smallest threshold whose kept total fits; only 0 and slope+1 can be minima.
  task automatic push_expect(input int budget, input int n);
    int best;
    int c;
    int cnt;
    int lat;
    if (n == 0) begin
      res_q.push_back('{0, 0, 2});
      return;
    end
    best = 65536;
    if (total_at(0, n) <= longint'(budget)) best = 0;
    for (int i = 0; i < n; i++) begin
      c = int'(tbl[i].slope) + 1;
      if (total_at(c, n) <= longint'(budget) && c < best) best = c;
    end
    lat = (best == 0) ? 2 + 2 * (n + 1) : 2 + 18 * (n + 1);
    res_q.push_back('{best, int'(total_at(best, n)), lat});
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (int'(tbl[i].slope) >= best) cnt++;
      if (i == n - 1 || tbl[i + 1].blk_id != tbl[i].blk_id) begin
        wr_q.push_back('{int'(tbl[i].blk_id), cnt});
        cnt = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.trunc_we) begin
      if (wr_q.size() == 0) chk("trunc_unexpected", 1, 0);
      else begin
        w = wr_q.pop_front();
        chk("trunc_addr", bus.trunc_addr, w.addr);
        chk("trunc_data", bus.trunc_data, w.data);
      end
    end
    if (bus.cal_truncation_point_over) begin
      over_cnt++;
      if (res_q.size() == 0) chk("over_unexpected", 1, 0);
      else begin
        r = res_q.pop_front();
        chk("threshold", bus.threshold, r.thr);
        chk("total_bytes", bus.total_bytes, r.tot);
        chk("latency", cyc - start_cyc, r.lat);
      end
    end
  end

  task automatic wait_over(input int base, input int lim);
    for (int i = 0; i < lim && over_cnt == base; i++) @(negedge clk);
    if (over_cnt == base) chk("over_timeout", 0, 1);
  endtask

  task automatic run(input int budget, input int n);
    int base;
    base = over_cnt;
    @(negedge clk);
    push_expect(budget, n);
    bus.byte_budget = ACC_W'(budget);
    bus.pass_count = (ADDR_W + 1)'(n);
    bus.cal_truncation_point_start = 1'b1;
    start_cyc = cyc;
    wait_over(base, 600);
    @(negedge clk);
    bus.cal_truncation_point_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("over_pulses", over_cnt, base + 1);
    chk("writes_left", wr_q.size(), 0);
  endtask

  task automatic set_entry(input int i, input int b, input int l, input int s);
    tbl[i] = '{blk_id: BLK_W'(b), len: LEN_W'(l), slope: SLOPE_W'(s)};
  endtask

  initial begin
    int base;
    cyc = 0; start_cyc = 0; over_cnt = 0; n_vec = 0; n_err = 0;
    rst = 1'b0;
    rst_syn = 1'b0;
    bus.cal_truncation_point_start = 1'b0;
    bus.byte_budget = '0;
    bus.pass_count = '0;
    set_entry(0, 0, 100, 900);
    set_entry(1, 0, 200, 500);
    set_entry(2, 0, 300, 100);
    set_entry(3, 1, 50, 800);
    set_entry(4, 1, 50, 300);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_over", bus.cal_truncation_point_over, 0);
    chk("rst_trunc_we", bus.trunc_we, 0);
    chk("rst_rd_en", bus.pass_rd_en, 0);
    chk("rst_threshold", bus.threshold, 0);
    chk("rst_total", bus.total_bytes, 0);

    run(400, 5);
    run(10000, 5);
    run(0, 5);

    // Synchronous clear in the middle of the search.
    base = over_cnt;
    @(negedge clk);
    bus.byte_budget = 24'd400;
    bus.pass_count = 11'd5;
    bus.cal_truncation_point_start = 1'b1;
    repeat (30) @(negedge clk);
    rst_syn = 1'b1;
    bus.cal_truncation_point_start = 1'b0;
    @(negedge clk);
    rst_syn = 1'b0;
    chk("syn_threshold", bus.threshold, 0);
    chk("syn_total", bus.total_bytes, 0);
    chk("syn_rd_en", bus.pass_rd_en, 0);
    chk("syn_over", bus.cal_truncation_point_over, 0);
    repeat (120) @(negedge clk);
    chk("syn_no_over", over_cnt, base);
    run(400, 5);

    run(400, 0);

    // Start held high past completion must not retrigger.
    base = over_cnt;
    @(negedge clk);
    push_expect(400, 5);
    bus.byte_budget = 24'd400;
    bus.pass_count = 11'd5;
    bus.cal_truncation_point_start = 1'b1;
    start_cyc = cyc;
    wait_over(base, 600);
    repeat (10) @(negedge clk);
    chk("hold_no_rerun", over_cnt, base + 1);
    bus.cal_truncation_point_start = 1'b0;
    repeat (2) @(negedge clk);
    push_expect(150, 5);
    bus.byte_budget = 24'd150;
    bus.cal_truncation_point_start = 1'b1;
    start_cyc = cyc;
    wait_over(base + 1, 600);
    @(negedge clk);
    bus.cal_truncation_point_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rerun_over_pulses", over_cnt, base + 2);
    chk("results_left", res_q.size(), 0);
    chk("final_writes_left", wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
